// File: rtl/music_pkg.sv
// Shared definitions for the music box playback path: FSM states, default
// field widths and the reserved note/duration codes.
package music_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_PLAY,
        ST_PAUSE
    } state_e;

    // ROM word layout is {note, dur}: note in the MSBs, duration in the LSBs.
    localparam int unsigned NOTE_WIDTH = 5;
    localparam int unsigned DUR_WIDTH  = 4;
    localparam int unsigned NOTE_REST  = 0;
    localparam int unsigned DUR_END    = 0;

endpackage

// File: rtl/beat_tick.sv
// Duration-unit prescaler: counts enabled cycles 0..TICK_DIV-1 and flags the
// last one. A synchronous clear restarts the count from zero.
module beat_tick #(
    parameter int unsigned TICK_DIV = 6250000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/song_sequencer.sv
// Playback controller: walks the note ROM one entry per note, times each note
// in duration ticks and handles play/pause and song selection pulses.
module song_sequencer
    import music_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 6250000,
    parameter int unsigned SONG_BITS = 3,
    parameter int unsigned SLOT_BITS = 5,
    parameter int unsigned NOTE_W    = NOTE_WIDTH,
    parameter int unsigned DUR_W     = DUR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           play,
    input  logic                           inc,
    input  logic                           dec,
    output logic [SONG_BITS+SLOT_BITS-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]        rom_data,
    output logic [NOTE_W-1:0]              note,
    output logic                           tone_en,
    output logic [SONG_BITS-1:0]           band,
    output logic                           playing,
    output logic                           beat
);

    localparam int unsigned AW = SONG_BITS + SLOT_BITS;

    state_e                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [NOTE_W-1:0]      note_q, note_d;
    logic [SONG_BITS-1:0]   band_q, band_d;
    logic [DUR_W-1:0]       dur_q, dur_d;

    logic                   band_evt;
    logic [SONG_BITS-1:0]   band_nxt;
    logic [NOTE_W-1:0]      rom_note;
    logic [DUR_W-1:0]       rom_dur;
    logic [SLOT_BITS-1:0]   slot, slot_inc;
    logic                   tick_en, tick_clr, tick;

    assign rom_note = rom_data[DUR_W +: NOTE_W];
    assign rom_dur  = rom_data[DUR_W-1:0];
    assign slot     = addr_q[SLOT_BITS-1:0];
    assign slot_inc = slot + 1'b1;
    assign band_evt = inc ^ dec;
    assign band_nxt = inc ? band_q + 1'b1 : band_q - 1'b1;

    // The prescaler holds on a cycle that pauses or changes song, so a pause
    // landing on a tick boundary neither loses nor double-counts that tick.
    assign tick_en  = (state_q == ST_PLAY) && !play && !band_evt;

    beat_tick #(.TICK_DIV(TICK_DIV)) u_beat_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (tick_en),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        note_d   = note_q;
        band_d   = band_q;
        dur_d    = dur_q;
        tick_clr = 1'b0;
        if (band_evt) begin
            band_d = band_nxt;
            if (state_q == ST_FETCH || state_q == ST_WAIT || state_q == ST_PLAY) begin
                addr_d  = {band_nxt, {SLOT_BITS{1'b0}}};
                state_d = ST_FETCH;
            end else if (state_q == ST_PAUSE) begin
                note_d  = NOTE_W'(NOTE_REST);
                state_d = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: if (play) begin
                    addr_d  = {band_q, {SLOT_BITS{1'b0}}};
                    state_d = ST_FETCH;
                end
                ST_FETCH: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (rom_dur != DUR_W'(DUR_END)) begin
                        note_d   = rom_note;
                        dur_d    = rom_dur;
                        tick_clr = 1'b1;
                        state_d  = ST_PLAY;
                    end else if (slot != '0) begin
                        addr_d  = {band_q, {SLOT_BITS{1'b0}}};
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (play) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        dur_d = dur_q - 1'b1;
                        if (dur_q == DUR_W'(1)) begin
                            addr_d  = {band_q, slot_inc};
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_PAUSE: if (play) state_d = ST_PLAY;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            note_q  <= '0;
            band_q  <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            band_q  <= band_d;
            dur_q   <= dur_d;
        end
    end

    assign rom_addr = addr_q;
    assign note     = note_q;
    assign band     = band_q;
    assign playing  = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_PLAY);
    assign tone_en  = (state_q == ST_PLAY) && (note_q != NOTE_W'(NOTE_REST));
    assign beat     = tick;

endmodule

// File: tb/tb_song_sequencer.sv
// Randomized bench for song_sequencer with a behavioural playback model that
// tracks elapsed cycles per note, plus hand-computed checkpoints.
module tb_song_sequencer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       play = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [7:0] rom_addr;
    logic [8:0] rom_data = '0;
    logic [4:0] note;
    logic       tone_en, playing, beat;
    logic [2:0] band;

    logic [8:0] rom [256];

    int total = 0;
    int bad   = 0;

    typedef enum {M_IDLE, M_FETCH, M_WAIT, M_PLAY, M_PAUSE} mode_t;
    mode_t m_mode;
    int    m_band, m_addr, m_note, m_e, m_total;

    song_sequencer #(
        .TICK_DIV  (TD),
        .SONG_BITS (3),
        .SLOT_BITS (5),
        .NOTE_W    (5),
        .DUR_W     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .play     (play),
        .inc      (inc),
        .dec      (dec),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .note     (note),
        .tone_en  (tone_en),
        .band     (band),
        .playing  (playing),
        .beat     (beat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic cmp(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", nm, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_band = 0; m_addr = 0; m_note = 0; m_e = 0; m_total = 0;
    endtask

    // Playback rules stated in elapsed cycles: a note of d units lasts d*TD
    // cycles in PLAY, with a beat on every TD-th of them.
    task automatic model_step(input bit p, input bit i, input bit d);
        int nb, w, du;
        if (i ^ d) begin
            nb = i ? (m_band + 1) % 8 : (m_band + 7) % 8;
            m_band = nb;
            if (m_mode == M_FETCH || m_mode == M_WAIT || m_mode == M_PLAY) begin
                m_addr = nb * 32;
                m_mode = M_FETCH;
            end else if (m_mode == M_PAUSE) begin
                m_note = 0;
                m_mode = M_IDLE;
            end
            return;
        end
        case (m_mode)
            M_IDLE: if (p) begin m_addr = m_band * 32; m_mode = M_FETCH; end
            M_FETCH: m_mode = M_WAIT;
            M_WAIT: begin
                w  = int'(rom[m_addr]);
                du = w % 16;
                if (du != 0) begin
                    m_note = w / 16; m_total = du * TD; m_e = 0; m_mode = M_PLAY;
                end else if (m_addr % 32 != 0) begin
                    m_addr = m_band * 32; m_mode = M_FETCH;
                end else begin
                    m_mode = M_IDLE;
                end
            end
            M_PLAY: begin
                if (p) m_mode = M_PAUSE;
                else if (m_e == m_total - 1) begin
                    m_addr = m_band * 32 + (m_addr % 32 + 1) % 32;
                    m_mode = M_FETCH;
                end else m_e++;
            end
            M_PAUSE: if (p) m_mode = M_PLAY;
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic compare();
        bit ep, et, eb;
        ep = (m_mode == M_FETCH) || (m_mode == M_WAIT) || (m_mode == M_PLAY);
        et = (m_mode == M_PLAY) && (m_note != 0);
        eb = (m_mode == M_PLAY) && !play && !(inc ^ dec) && (m_e % TD == TD - 1);
        cmp("rom_addr", int'(rom_addr), m_addr);
        cmp("note", int'(note), m_note);
        cmp("band", int'(band), m_band);
        cmp("playing", int'(playing), int'(ep));
        cmp("tone_en", int'(tone_en), int'(et));
        cmp("beat", int'(beat), int'(eb));
    endtask

    task automatic step(input bit p, input bit i, input bit d);
        @(negedge clk);
        play = p; inc = i; dec = d;
        #1 compare();
        @(posedge clk);
        model_step(p, i, d);
        #1;
        play = 1'b0; inc = 1'b0; dec = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        cmp({nm, "_addr"}, int'(rom_addr), 0);
        cmp({nm, "_note"}, int'(note), 0);
        cmp({nm, "_tone"}, int'(tone_en), 0);
        cmp({nm, "_band"}, int'(band), 0);
        cmp({nm, "_playing"}, int'(playing), 0);
        cmp({nm, "_beat"}, int'(beat), 0);
    endtask

    task automatic async_reset(input string nm);
        @(negedge clk);
        #3 rst = 1'b1;
        #1 check_zero(nm);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int len;
        for (int a = 0; a < 256; a++) rom[a] = '0;
        rom[0] = {5'd5, 4'd2};
        rom[1] = {5'd0, 4'd1};
        rom[2] = {5'd9, 4'd1};
        rom[3] = {5'd3, 4'd0};
        for (int s = 0; s < 32; s++)
            rom[32 + s] = {5'($urandom_range(0, 31)), 4'($urandom_range(1, 3))};
        for (int g = 3; g < 8; g++) begin
            len = $urandom_range(1, 8);
            for (int s = 0; s < len; s++)
                rom[g * 32 + s] = {5'($urandom_range(0, 31)), 4'($urandom_range(1, 3))};
            rom[g * 32 + len] = {5'($urandom_range(0, 31)), 4'd0};
        end

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_zero("reset");

        repeat (8) step(0, 0, 0);
        step(1, 0, 0);
        cmp("lit_fetch_playing", int'(playing), 1);
        cmp("lit_fetch_addr", int'(rom_addr), 0);
        step(0, 0, 0);
        cmp("lit_wait_tone", int'(tone_en), 0);
        step(0, 0, 0);
        cmp("lit_note5", int'(note), 5);
        cmp("lit_note5_tone", int'(tone_en), 1);
        repeat (3) step(0, 0, 0);
        cmp("lit_beat1", int'(beat), 1);
        repeat (4) step(0, 0, 0);
        cmp("lit_beat2", int'(beat), 1);
        step(0, 0, 0);
        cmp("lit_fetch1_addr", int'(rom_addr), 1);
        cmp("lit_fetch1_tone", int'(tone_en), 0);
        repeat (2) step(0, 0, 0);
        cmp("lit_rest_note", int'(note), 0);
        cmp("lit_rest_tone", int'(tone_en), 0);
        cmp("lit_rest_playing", int'(playing), 1);
        repeat (14) step(0, 0, 0);
        cmp("lit_loop_addr", int'(rom_addr), 0);
        cmp("lit_loop_note", int'(note), 5);
        cmp("lit_loop_tone", int'(tone_en), 1);

        repeat (2) step(0, 0, 0);
        step(1, 0, 0);
        cmp("lit_pause_tone", int'(tone_en), 0);
        repeat (20) step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        cmp("lit_resume_beat1", int'(beat), 1);
        repeat (4) step(0, 0, 0);
        cmp("lit_resume_beat2", int'(beat), 1);
        step(0, 0, 0);
        cmp("lit_resume_next_addr", int'(rom_addr), 1);

        repeat (2) step(0, 0, 0);
        step(0, 1, 0);
        cmp("lit_inc_band", int'(band), 1);
        cmp("lit_inc_addr", int'(rom_addr), 32);
        cmp("lit_inc_playing", int'(playing), 1);
        repeat (6) step(0, 1, 0);
        cmp("lit_band7", int'(band), 7);
        step(0, 1, 0);
        cmp("lit_wrap_up", int'(band), 0);
        step(0, 0, 1);
        cmp("lit_wrap_down", int'(band), 7);
        step(0, 1, 1);
        cmp("lit_incdec_band", int'(band), 7);
        cmp("lit_incdec_addr", int'(rom_addr), 224);
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        cmp("lit_pause_inc_band", int'(band), 0);
        cmp("lit_pause_inc_note", int'(note), 0);
        cmp("lit_pause_inc_playing", int'(playing), 0);
        step(1, 1, 0);
        cmp("lit_idle_playinc_band", int'(band), 1);
        cmp("lit_idle_playinc_playing", int'(playing), 0);

        step(0, 1, 0);
        step(1, 0, 0);
        cmp("lit_empty_fetch", int'(rom_addr), 64);
        step(0, 0, 0);
        step(0, 0, 0);
        cmp("lit_empty_idle", int'(playing), 0);

        step(0, 1, 0);
        step(1, 0, 0);
        repeat (2) step(0, 0, 0);
        async_reset("rst_play");

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) async_reset("rst_rand");
            else step($urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0,
                      $urandom_range(0, 79) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Playback controller for the music box tone datapath. Walks a synchronous note ROM (note code + duration per entry), times each note with a beat prescaler, and drives the tone generator's note select and enable. Handles play/pause and next/previous song from the debounced button pulses, and exports the current song number to the 7-segment display and a beat strobe to the LEDs.

Parameters:
TICK_DIV, 6250000, clk cycles per duration unit (62.5 ms at 100 MHz); must be >= 2
SONG_BITS, 3, log2 of song count; 8 songs
SLOT_BITS, 5, log2 of ROM entries per song; 32 entries
NOTE_W, 5, note code width; code 0 = rest
DUR_W, 4, duration field width in ticks; 0 = end-of-song marker

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
play  in  1  one-cycle debounced pulse; start / pause / resume
inc  in  1  one-cycle pulse; next song
dec  in  1  one-cycle pulse; previous song
rom_addr  out  SONG_BITS+SLOT_BITS  note ROM address, registered
rom_data  in  NOTE_W+DUR_W  {note, dur}; valid one cycle after rom_addr
note  out  NOTE_W  note code to tone generator, registered
tone_en  out  1  tone generator enable
band  out  SONG_BITS  current song number
playing  out  1  high in FETCH, WAIT, PLAY
beat  out  1  one-cycle pulse per duration tick while in PLAY

Behaviour:
- Reset: state IDLE; rom_addr=0, note=0, tone_en=0, band=0, playing=0, beat=0, tick counter=0, dur_cnt=0.
- Song base address = {band, SLOT_BITS'b0}. Slot increment wraps 31->0 within the same song; band bits never change on increment.
- States: IDLE, FETCH, WAIT, PLAY, PAUSE.
- IDLE: tone_en=0. On play: rom_addr<=base, go to FETCH.
- FETCH: one cycle. The ROM samples rom_addr. Go to WAIT.
- WAIT: rom_data is valid.
  - If dur!=0: note<=rom_data note, dur_cnt<=dur, clear tick counter, go to PLAY.
  - If dur==0 and the slot is not 0: rom_addr<=base, go to FETCH (song loops).
  - If dur==0 at slot 0 (empty song): go to IDLE.
- PLAY: tone_en = (note!=0). The tick counter counts 0..TICK_DIV-1. At TICK_DIV-1 it asserts beat and decrements dur_cnt. When dur_cnt==1 at a tick: rom_addr<=rom_addr slot+1, go to FETCH. tone_en drops during FETCH/WAIT, giving a 2-cycle articulation gap.
- PLAY + play: go to PAUSE. tone_en=0 from the next cycle. Tick counter, dur_cnt and note are frozen.
- PAUSE + play: go to PLAY and resume the same note with the remaining count.
- Latency: a play pulse sampled at edge k in IDLE gives FETCH after k, WAIT after k+1, and note/tone_en valid after k+2.
- inc/dec:
  - band<=band±1, modulo 2^SONG_BITS (7+1->0, 0-1->7).
  - If in FETCH/WAIT/PLAY: rom_addr<=new base, go to FETCH (restart on the new song).
  - If in PAUSE: go to IDLE, note<=0.
  - If in IDLE: stay in IDLE.
- Simultaneous events:
  - inc and dec in the same cycle: both ignored.
  - inc/dec together with play: the band change wins and play is ignored that cycle.
- beat is only asserted in PLAY. tone_en is only asserted in PLAY. Outputs are registered (tone_en may be decoded from state and note).
- Asynchronous rst at any time returns all outputs to reset values immediately.

Decomposition:
- Shared package (music_pkg): state encoding constants; NOTE_REST=0; DUR_END=0; field widths NOTE_W and DUR_W; ROM word layout (note in the MSBs, dur in the LSBs).
- One sub-module: beat_tick. A prescaler with enable and synchronous clear, parameter TICK_DIV, outputting a one-cycle tick. song_sequencer instantiates it with enable = (state==PLAY) and clear = WAIT->PLAY.

Test Plan:
All tests use TICK_DIV=4 and ROM song 0 = {note5,dur2},{rest,dur1},{note9,dur1},{x,dur0}.
- Reset, then play at cycle 10 -> rom_addr=0 at 11, note=5 with tone_en=1 at 12; beats at 15 and 19; FETCH of addr 1 at 20; note=0 with tone_en=0 (rest) at 22.
- Let the song run to the dur0 entry -> rom_addr returns to 0 and note 5 replays; playing stays 1 throughout, and tone_en has 2-cycle gaps.
- Play mid-note, wait 20 cycles, then play again -> tone_en=0 and beat=0 while paused; after resume, the remaining duration exactly matches the unpaused count.
- While playing song 0, pulse inc -> band=1, rom_addr=0x20 next cycle, playing continues. With band=7, pulse inc -> band=0. With band=0, pulse dec -> band=7.
- inc and dec in the same cycle -> band unchanged and state unchanged. play with inc in IDLE -> band+1, state stays IDLE.
- Empty song (slot 0 has dur=0), then play -> FETCH, WAIT, IDLE; tone_en is never asserted. Assert rst during PLAY -> all outputs are 0 and band=0 asynchronously.
